// File: rtl/pid_tracker.sv
// pid_tracker: captures and validates the PID byte of each received USB packet and
// pushes it to the PID FIFO only when the packet ends cleanly. Build option PID_TRACKER_LEN_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for rx_sop
// PID_WAIT | packet started, PID byte not yet received
// BODY     | valid PID captured, counting payload bytes
// COMMIT   | write strobe cycle of a cleanly terminated packet
// DROP     | packet rejected, waiting for rx_eop or timeout
module pid_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 640,
    parameter int unsigned TO_W           = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_sop,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_eop,
    input  logic       rx_err,
    input  logic       fifo_full,
    output logic       fifo_w_enable,
    output logic [7:0] fifo_w_data,
    output logic       pid_err,
    output logic       overflow,
    output logic [7:0] drop_count,
    output logic [6:0] byte_count
);

`ifdef PID_TRACKER_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    // Down-counter reloaded on activity; reaching zero with another idle cycle is a timeout.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PID_WAIT,
        BODY,
        COMMIT,
        DROP
    } state_t;

    state_t          state;
    logic [7:0]      pid_q;
    logic [TO_W-1:0] to_cnt;

    logic            pid_ok;
    logic            timeout;
    logic [6:0]      bc_inc;
    logic [7:0]      drop_inc;
    logic [7:0]      commit_pid;
    logic [6:0]      commit_cnt;
    logic            len_ok;

    always_comb begin
        pid_ok     = (rx_byte[7:4] == ~rx_byte[3:0]);
        timeout    = !rx_byte_valid && (to_cnt == '0);
        bc_inc     = (byte_count == 7'd127) ? byte_count : byte_count + 7'd1;
        drop_inc   = (drop_count == 8'd255) ? drop_count : drop_count + 8'd1;
        // A PID byte arriving together with rx_eop commits straight from PID_WAIT.
        commit_pid = (state == PID_WAIT) ? rx_byte : pid_q;
        commit_cnt = (state == PID_WAIT) ? 7'd1 : (rx_byte_valid ? bc_inc : byte_count);
        len_ok     = 1'b1;
        if (LEN_CHECK) begin
            case (commit_pid[1:0])
                2'b01:   len_ok = (commit_cnt == 7'd3);
                2'b10:   len_ok = (commit_cnt == 7'd1);
                default: len_ok = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state         <= IDLE;
            pid_q         <= '0;
            to_cnt        <= '0;
            fifo_w_enable <= 1'b0;
            fifo_w_data   <= '0;
            pid_err       <= 1'b0;
            overflow      <= 1'b0;
            drop_count    <= '0;
            byte_count    <= '0;
        end else begin
            fifo_w_enable <= 1'b0;
            pid_err       <= 1'b0;
            if (rx_sop) begin
                // The COMMIT packet is already complete, so a new SYNC there is not an abort.
                if (state != IDLE && state != COMMIT) begin
                    drop_count <= drop_inc;
                end
                state      <= PID_WAIT;
                byte_count <= '0;
                to_cnt     <= TO_LOAD;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    PID_WAIT: begin
                        if (rx_byte_valid) begin
                            pid_q      <= rx_byte;
                            byte_count <= 7'd1;
                            to_cnt     <= TO_LOAD;
                            if (!pid_ok) begin
                                pid_err    <= 1'b1;
                                drop_count <= drop_inc;
                                state      <= rx_eop ? IDLE : DROP;
                            end else if (rx_err) begin
                                drop_count <= drop_inc;
                                state      <= rx_eop ? IDLE : DROP;
                            end else if (rx_eop) begin
                                if (!len_ok) begin
                                    drop_count <= drop_inc;
                                    state      <= IDLE;
                                end else begin
                                    state <= COMMIT;
                                    if (fifo_full) begin
                                        overflow <= 1'b1;
                                    end else begin
                                        fifo_w_enable <= 1'b1;
                                        fifo_w_data   <= commit_pid;
                                    end
                                end
                            end else begin
                                state <= BODY;
                            end
                        end else if (rx_eop) begin
                            pid_err    <= 1'b1;
                            drop_count <= drop_inc;
                            state      <= IDLE;
                        end else if (rx_err || timeout) begin
                            drop_count <= drop_inc;
                            state      <= DROP;
                            to_cnt     <= TO_LOAD;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                    BODY: begin
                        if (rx_byte_valid) begin
                            byte_count <= bc_inc;
                            to_cnt     <= TO_LOAD;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                        if (rx_err) begin
                            drop_count <= drop_inc;
                            state      <= rx_eop ? IDLE : DROP;
                            to_cnt     <= TO_LOAD;
                        end else if (rx_eop) begin
                            if (!len_ok) begin
                                drop_count <= drop_inc;
                                state      <= IDLE;
                            end else begin
                                state <= COMMIT;
                                if (fifo_full) begin
                                    overflow <= 1'b1;
                                end else begin
                                    fifo_w_enable <= 1'b1;
                                    fifo_w_data   <= commit_pid;
                                end
                            end
                        end else if (timeout) begin
                            drop_count <= drop_inc;
                            state      <= DROP;
                            to_cnt     <= TO_LOAD;
                        end
                    end
                    COMMIT: begin
                        state <= IDLE;
                    end
                    DROP: begin
                        if (rx_eop || timeout) begin
                            state <= IDLE;
                        end else if (rx_byte_valid) begin
                            to_cnt <= TO_LOAD;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_tracker.sv
// tb_pid_tracker: randomized packet stimulus against a packet-level reference model;
// expected FIFO writes are queued and matched by an independent output monitor.
module tb_pid_tracker;

    localparam int T = 24;

`ifdef PID_TRACKER_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    localparam int E_EOP     = 0;
    localparam int E_ERR     = 1;
    localparam int E_ERR_EOP = 2;
    localparam int E_TIMEOUT = 3;
    localparam int E_NOPID   = 4;
    localparam int E_SILENT  = 5;
    localparam int E_ABORT   = 6;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       rx_sop = 1'b0;
    logic       rx_byte_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_eop = 1'b0;
    logic       rx_err = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_w_enable;
    logic [7:0] fifo_w_data;
    logic       pid_err;
    logic       overflow;
    logic [7:0] drop_count;
    logic [6:0] byte_count;

    pid_tracker #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rx_sop       (rx_sop),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .rx_eop       (rx_eop),
        .rx_err       (rx_err),
        .fifo_full    (fifo_full),
        .fifo_w_enable(fifo_w_enable),
        .fifo_w_data  (fifo_w_data),
        .pid_err      (pid_err),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         pid_err_seen = 0;
    int         exp_drop = 0;
    int         exp_pid_err = 0;
    int         exp_ovf = 0;

    logic [7:0] good_pids[10] = '{8'hE1, 8'h69, 8'hA5, 8'h2D, 8'hC3,
                                  8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h87};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: every write strobe must match the oldest expected PID.
    always @(negedge clk) begin
        if (n_rst) begin
            pid_err_seen = 0;
        end else begin
            if (pid_err) pid_err_seen++;
            if (fifo_w_enable) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got data %02h, expected no write", fifo_w_data);
                end else begin
                    check("write_data", fifo_w_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit len_ok(input logic [7:0] p, input int bc);
        if (LEN_CHECK && p[1:0] == 2'b01) return bc == 3;
        if (LEN_CHECK && p[1:0] == 2'b10) return bc == 1;
        return 1'b1;
    endfunction

    function automatic int rgap();
        return ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 2));
    endfunction

    task automatic pulse(input bit s, input bit v, input logic [7:0] b, input bit e, input bit r);
        rx_sop = s;
        rx_byte_valid = v;
        rx_byte = b;
        rx_eop = e;
        rx_err = r;
        @(posedge clk);
        #1;
        rx_sop = 1'b0;
        rx_byte_valid = 1'b0;
        rx_eop = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sop();
        pulse(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_eop();
        pulse(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_eop);
        pulse(1'b0, 1'b1, b, with_eop, 1'b0);
    endtask

    task automatic post_checks(input int bc);
        check("drop_count", drop_count, sat(exp_drop, 255));
        check("byte_count", byte_count, bc);
        check("overflow", overflow, exp_ovf);
        check("pid_err_pulses", pid_err_seen, exp_pid_err);
        check("pending_writes", exp_q.size(), 0);
    endtask

    // One packet: sop, optional PID + n body bytes, then the chosen termination.
    task automatic send_packet(input logic [7:0] p, input int n, input int term,
                               input bit full, input bit tie);
        bit good;
        bit wr;
        int bc;
        good = (p[7:4] == ~p[3:0]);
        wr = 1'b0;
        bc = good ? sat(n + 1, 127) : 1;
        fifo_full = full;
        send_sop();
        if (term == E_NOPID) begin
            exp_pid_err++;
            exp_drop++;
            bc = 0;
            idle(rgap());
            send_eop();
        end else if (term == E_SILENT) begin
            exp_drop++;
            bc = 0;
            idle(2 * T + 4);
        end else begin
            if (!good) begin
                exp_pid_err++;
                exp_drop++;
            end
            if (term == E_EOP && good) begin
                if (!len_ok(p, bc)) exp_drop++;
                else if (full) exp_ovf = 1;
                else begin
                    wr = 1'b1;
                    exp_q.push_back(p);
                end
            end
            idle(rgap());
            send_byte(p, tie && term == E_EOP && n == 0);
            for (int i = 0; i < n; i++) begin
                idle(rgap());
                send_byte(8'($urandom), tie && term == E_EOP && i == n - 1);
            end
            case (term)
                E_EOP: begin
                    if (!tie) begin
                        idle(rgap());
                        send_eop();
                    end
                    @(negedge clk);
                    check("write_strobe_after_eop", fifo_w_enable, wr);
                end
                E_ERR: begin
                    if (good) exp_drop++;
                    idle(rgap());
                    pulse(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                    idle(rgap());
                    send_eop();
                end
                E_ERR_EOP: begin
                    if (good) exp_drop++;
                    idle(rgap());
                    pulse(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
                end
                E_TIMEOUT: begin
                    if (good) exp_drop++;
                    idle(T);
                    send_eop();
                end
                default: begin
                    // left open: the next packet's sop aborts it
                    exp_drop++;
                    idle($urandom_range(0, 2));
                    return;
                end
            endcase
        end
        idle(2);
        @(negedge clk);
        post_checks(bc);
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        rx_sop = 1'b0;
        rx_byte_valid = 1'b0;
        rx_eop = 1'b0;
        rx_err = 1'b0;
        fifo_full = 1'b0;
        exp_drop = 0;
        exp_pid_err = 0;
        exp_ovf = 0;
        exp_q.delete();
        idle(3);
        n_rst = 1'b0;
        idle(1);
        @(negedge clk);
        check("rst_fifo_w_enable", fifo_w_enable, 0);
        check("rst_fifo_w_data", fifo_w_data, 0);
        check("rst_pid_err", pid_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_byte_count", byte_count, 0);
    endtask

    initial begin
        int r;
        int term;
        logic [7:0] p;

        do_reset();

        send_packet(8'h69, 2, E_EOP, 1'b0, 1'b0);
        send_packet(8'h6A, 0, E_EOP, 1'b0, 1'b0);
        send_packet(8'hD2, 0, E_EOP, 1'b1, 1'b0);
        send_packet(8'hC3, 1, E_EOP, 1'b0, 1'b1);
        send_packet(8'hC3, 5, E_ERR, 1'b0, 1'b0);
        send_packet(8'hC3, 0, E_TIMEOUT, 1'b0, 1'b0);
        send_packet(8'h4B, 2, E_ABORT, 1'b0, 1'b0);
        send_packet(8'hD2, 0, E_EOP, 1'b0, 1'b0);
        send_packet(8'hD2, 1, E_EOP, 1'b0, 1'b0);
        send_packet(8'hC3, 140, E_EOP, 1'b0, 1'b0);
        send_packet(8'hA5, 2, E_ERR_EOP, 1'b0, 1'b0);
        send_packet(8'h00, 0, E_SILENT, 1'b0, 1'b0);

        // back-to-back: second sop lands in the COMMIT cycle of the first packet
        fifo_full = 1'b0;
        send_sop();
        send_byte(8'hC3, 1'b0);
        send_byte(8'h55, 1'b0);
        exp_q.push_back(8'hC3);
        send_eop();
        send_sop();
        send_byte(8'h4B, 1'b0);
        exp_q.push_back(8'h4B);
        send_eop();
        idle(2);
        @(negedge clk);
        post_checks(1);

        // reset in the middle of a good packet discards it
        send_sop();
        send_byte(8'h69, 1'b0);
        send_byte(8'h11, 1'b0);
        do_reset();
        send_byte(8'h22, 1'b0);
        send_eop();
        idle(2);
        @(negedge clk);
        post_checks(0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            term = (r < 4) ? E_EOP : (r == 4) ? E_ERR : (r == 5) ? E_ERR_EOP :
                   (r == 6) ? E_TIMEOUT : (r == 7) ? E_NOPID : (r == 8) ? E_SILENT : E_ABORT;
            p = ($urandom_range(0, 9) < 7) ? good_pids[$urandom_range(0, 9)] : 8'($urandom);
            send_packet(p, $urandom_range(0, 4), term, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 1) == 1);
        end

        for (int k = 0; k < 260; k++) begin
            send_packet(8'h00, 0, E_NOPID, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
